// File: rtl/rf_pkg.sv
// Shared register-file types: address/data widths and the writeback payload.
package rf_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xdata_t;

    typedef struct packed {
        reg_addr_t rd;
        xdata_t    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO buffering ALU results ahead of the register-file write port.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  wb_entry_t i_data,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign o_head  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_push) wr_ptr <= wr_ptr + CNT_W'(1);
            if (i_pop)  rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem[wr_ptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/rf_writeback.sv
// Merges ALU and load results onto the single RF write port and tracks
// outstanding destination registers for issue-stage hazard stalls.
module rf_writeback
    import rf_pkg::*;
#(
    parameter int unsigned ALU_DEPTH  = 4,
    parameter int unsigned STARVE_MAX = 8,
    parameter bit          BYPASS_EN  = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_iss_valid,
    input  logic [4:0]          i_iss_rd,
    output logic                o_iss_ready,
    input  logic [4:0]          i_rs1_raddr,
    input  logic [4:0]          i_rs2_raddr,
    output logic                o_rs1_busy,
    output logic                o_rs2_busy,
    input  logic                i_alu_valid,
    input  logic [4:0]          i_alu_rd,
    input  logic [31:0]         i_alu_data,
    output logic                o_alu_ready,
    input  logic                i_lsu_valid,
    input  logic [4:0]          i_lsu_rd,
    input  logic [31:0]         i_lsu_data,
    output logic                o_lsu_ready,
    output logic                o_rd_wen,
    output logic [4:0]          o_rd_waddr,
    output logic [31:0]         o_rd_wdata,
    output logic [31:0]         o_pend,
    output logic                o_err
);

    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    wb_entry_t           alu_in;
    wb_entry_t           alu_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                alu_push;
    logic                alu_pop;
    logic                alu_force;
    logic                lsu_acc;
    logic [SW-1:0]       starve_cnt;
    logic [SW-1:0]       starve_nxt;
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_nxt;
    logic                err_nxt;
    logic                wen_nxt;
    reg_addr_t           waddr_nxt;
    xdata_t              wdata_nxt;

    assign alu_in      = '{rd: i_alu_rd, data: i_alu_data};
    assign o_alu_ready = !fifo_full;
    assign alu_push    = i_alu_valid && !fifo_full;

    wb_fifo #(.DEPTH(ALU_DEPTH)) u_alu_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (alu_push),
        .i_data  (alu_in),
        .i_pop   (alu_pop),
        .o_head  (alu_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // A starved ALU head pre-empts the LSU; otherwise loads have priority.
    assign alu_force   = (starve_cnt == SW'(STARVE_MAX)) && !fifo_empty;
    assign o_lsu_ready = !alu_force;
    assign lsu_acc     = i_lsu_valid && !alu_force;
    assign alu_pop     = !fifo_empty && !lsu_acc;

    assign o_iss_ready = !pend_q[i_iss_rd];
    assign o_pend      = pend_q;
    assign o_rs1_busy  = pend_q[i_rs1_raddr] &&
                         !(BYPASS_EN && o_rd_wen && (o_rd_waddr == i_rs1_raddr));
    assign o_rs2_busy  = pend_q[i_rs2_raddr] &&
                         !(BYPASS_EN && o_rd_wen && (o_rd_waddr == i_rs2_raddr));

    always_comb begin
        wen_nxt    = 1'b0;
        waddr_nxt  = o_rd_waddr;
        wdata_nxt  = o_rd_wdata;
        starve_nxt = starve_cnt;
        pend_nxt   = pend_q;
        err_nxt    = o_err;

        // Winner selection; x0 results are consumed but never written.
        if (lsu_acc) begin
            wen_nxt   = (i_lsu_rd != '0);
            waddr_nxt = i_lsu_rd;
            wdata_nxt = i_lsu_data;
        end else if (alu_pop) begin
            wen_nxt   = (alu_head.rd != '0);
            waddr_nxt = alu_head.rd;
            wdata_nxt = alu_head.data;
        end

        if (fifo_empty || alu_pop) begin
            starve_nxt = '0;
        end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_nxt = starve_cnt + SW'(1);
        end

        if (o_rd_wen) pend_nxt[o_rd_waddr] = 1'b0;
        if (i_iss_valid && o_iss_ready) pend_nxt[i_iss_rd] = 1'b1;
        pend_nxt[0] = 1'b0;

        // Results are checked against the scoreboard as they are accepted.
        if (lsu_acc && (i_lsu_rd != '0) && !pend_q[i_lsu_rd]) err_nxt = 1'b1;
        if (alu_push && (i_alu_rd != '0) && !pend_q[i_alu_rd]) err_nxt = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_wen   <= 1'b0;
            o_rd_waddr <= '0;
            o_rd_wdata <= '0;
            starve_cnt <= '0;
            pend_q     <= '0;
            o_err      <= 1'b0;
        end else begin
            o_rd_wen   <= wen_nxt;
            o_rd_waddr <= waddr_nxt;
            o_rd_wdata <= wdata_nxt;
            starve_cnt <= starve_nxt;
            pend_q     <= pend_nxt;
            o_err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback; a second instance with BYPASS_EN=0 shares the stimulus.
module tb_rf_writeback;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;

    logic        iss_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready, rd_wen, err;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata, pend;

    logic        iss_ready_nb, rs1_busy_nb, rs2_busy_nb, alu_ready_nb, lsu_ready_nb, rd_wen_nb, err_nb;
    logic [4:0]  rd_waddr_nb;
    logic [31:0] rd_wdata_nb, pend_nb;

    int n_checks = 0;
    int n_err    = 0;

    rf_writeback #(.ALU_DEPTH(4), .STARVE_MAX(8), .BYPASS_EN(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_iss_valid(iss_valid), .i_iss_rd(iss_rd), .o_iss_ready(iss_ready),
        .i_rs1_raddr(rs1), .i_rs2_raddr(rs2), .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
        .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
        .i_lsu_valid(lsu_valid), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data), .o_lsu_ready(lsu_ready),
        .o_rd_wen(rd_wen), .o_rd_waddr(rd_waddr), .o_rd_wdata(rd_wdata),
        .o_pend(pend), .o_err(err)
    );

    rf_writeback #(.ALU_DEPTH(4), .STARVE_MAX(8), .BYPASS_EN(1'b0)) dut_nb (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_iss_valid(iss_valid), .i_iss_rd(iss_rd), .o_iss_ready(iss_ready_nb),
        .i_rs1_raddr(rs1), .i_rs2_raddr(rs2), .o_rs1_busy(rs1_busy_nb), .o_rs2_busy(rs2_busy_nb),
        .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .o_alu_ready(alu_ready_nb),
        .i_lsu_valid(lsu_valid), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data), .o_lsu_ready(lsu_ready_nb),
        .o_rd_wen(rd_wen_nb), .o_rd_waddr(rd_waddr_nb), .o_rd_wdata(rd_wdata_nb),
        .o_pend(pend_nb), .o_err(err_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iss;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_wen;
        logic        exp_busy_nb;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1'b1; iss_rd = rd;
        tick();
        iss_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd1,  32'h0000_0001, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 5'd15, 32'hA5A5_5A5A, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 5'd0,  32'h0000_1234, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 5'd2,  32'h0000_0000, 1'b1, 1'b1};

        rst_n = 1'b1;
        idle_inputs();
        #2;
        do_reset();

        // Reset state
        chk("rst_wen",   32'(rd_wen), 32'd0);
        chk("rst_waddr", 32'(rd_waddr), 32'd0);
        chk("rst_wdata", rd_wdata, 32'd0);
        chk("rst_pend",  pend, 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);

        // Mid-stream reset with three buffered ALU entries
        issue(5'd4);
        chk("pend4_set", pend, 32'h0000_0010);
        lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h55;
        alu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_rd = 5'(10 + i); alu_data = 32'(i + 100);
            tick();
        end
        alu_valid = 1'b0;
        chk("pre_rst_wen", 32'(rd_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wen",   32'(rd_wen), 32'd0);
        chk("mid_rst_waddr", 32'(rd_waddr), 32'd0);
        chk("mid_rst_wdata", rd_wdata, 32'd0);
        chk("mid_rst_pend",  pend, 32'd0);
        chk("mid_rst_err",   32'(err), 32'd0);
        lsu_valid = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_write", 32'(rd_wen), 32'd0);
        end
        // FIFO must hold four new entries before reporting full
        lsu_valid = 1'b1; lsu_rd = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("fill_alu_ready", 32'(alu_ready), 32'd1);
            tick();
        end
        chk("fifo_full", 32'(alu_ready), 32'd0);
        do_reset();

        // Table-driven LSU writes
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].iss) issue(vecs[i].rd);
            lsu_valid = 1'b1; lsu_rd = vecs[i].rd; lsu_data = vecs[i].data;
            rs1 = vecs[i].rd;
            #1 chk("vec_lsu_ready", 32'(lsu_ready), 32'd1);
            tick();
            lsu_valid = 1'b0;
            #1;
            chk("vec_wen", 32'(rd_wen), 32'(vecs[i].exp_wen));
            if (vecs[i].exp_wen) begin
                chk("vec_waddr", 32'(rd_waddr), 32'(vecs[i].rd));
                chk("vec_wdata", rd_wdata, vecs[i].data);
            end
            chk("vec_busy_byp", 32'(rs1_busy), 32'd0);
            chk("vec_busy_nobyp", 32'(rs1_busy_nb), 32'(vecs[i].exp_busy_nb));
            tick();
            chk("vec_pend_clear", pend, 32'd0);
            chk("vec_err", 32'(err), 32'd0);
        end
        rs1 = '0;

        // ALU x5 = DEADBEEF, two-cycle latency
        issue(5'd5);
        chk("x5_pend", pend, 32'h0000_0020);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        tick();
        alu_valid = 1'b0;
        chk("x5_lat1", 32'(rd_wen), 32'd0);
        tick();
        chk("x5_wen", 32'(rd_wen), 32'd1);
        chk("x5_waddr", 32'(rd_waddr), 32'd5);
        chk("x5_wdata", rd_wdata, 32'hDEAD_BEEF);
        chk("x5_pend_held", pend, 32'h0000_0020);
        tick();
        chk("x5_pend_clr", pend, 32'd0);
        chk("x5_wen_drop", 32'(rd_wen), 32'd0);

        // LSU x7 and ALU x8 same cycle: LSU first
        issue(5'd7);
        issue(5'd8);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h22;
        tick();
        lsu_valid = 1'b0; alu_valid = 1'b0;
        chk("x7_waddr", 32'(rd_waddr), 32'd7);
        chk("x7_wdata", rd_wdata, 32'h11);
        tick();
        chk("x8_wen", 32'(rd_wen), 32'd1);
        chk("x8_waddr", 32'(rd_waddr), 32'd8);
        chk("x8_wdata", rd_wdata, 32'h22);
        tick();
        chk("x78_pend_clr", pend, 32'd0);

        // Starvation: continuous x0 loads, one ALU entry to x20
        issue(5'd20);
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020_2020;
        tick();
        alu_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("starve_lsu_ready", 32'(lsu_ready), 32'd1);
            chk("starve_no_wen", 32'(rd_wen), 32'd0);
            tick();
        end
        chk("starve_forced_lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        chk("starve_wen", 32'(rd_wen), 32'd1);
        chk("starve_waddr", 32'(rd_waddr), 32'd20);
        chk("starve_wdata", rd_wdata, 32'h2020_2020);
        chk("starve_lsu_ready_back", 32'(lsu_ready), 32'd1);
        lsu_valid = 1'b0;
        tick();
        chk("starve_pend_clr", pend, 32'd0);

        // Double claim of x3 and bypass masking
        iss_valid = 1'b1; iss_rd = 5'd3;
        #1 chk("x3_first_ready", 32'(iss_ready), 32'd1);
        tick();
        rs1 = 5'd3; rs2 = 5'd3;
        #1;
        chk("x3_second_ready", 32'(iss_ready), 32'd0);
        chk("x3_busy_pre", 32'(rs1_busy), 32'd1);
        chk("x3_busy2_pre", 32'(rs2_busy), 32'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
        tick();
        lsu_valid = 1'b0;
        #1;
        chk("x3_wen", 32'(rd_wen), 32'd1);
        chk("x3_busy_byp", 32'(rs1_busy), 32'd0);
        chk("x3_busy2_byp", 32'(rs2_busy), 32'd0);
        chk("x3_busy_nobyp", 32'(rs1_busy_nb), 32'd1);
        chk("x3_ready_wen_cycle", 32'(iss_ready), 32'd0);
        tick();
        chk("x3_ready_after", 32'(iss_ready), 32'd1);
        chk("x3_busy_clear", 32'(rs1_busy), 32'd0);
        tick();
        iss_valid = 1'b0;
        chk("x3_reclaimed", pend, 32'h0000_0008);
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h34;
        tick();
        lsu_valid = 1'b0;
        tick();
        chk("x3_final_clr", pend, 32'd0);
        chk("x3_no_err", 32'(err), 32'd0);
        rs1 = '0; rs2 = '0;

        // x0 result and a result for non-pending x9
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("x0_no_wen", 32'(rd_wen), 32'd0);
        chk("x0_no_err", 32'(err), 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0;
        chk("x9_err_set", 32'(err), 32'd1);
        tick();
        chk("x9_wen", 32'(rd_wen), 32'd1);
        chk("x9_waddr", 32'(rd_waddr), 32'd9);
        chk("x9_wdata", rd_wdata, 32'h99);
        repeat (2) tick();
        chk("x9_err_sticky", 32'(err), 32'd1);
        chk("x9_pend_zero", pend, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
